// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Optional build macro CONTROL_FSM_JUMP_EN makes the j opcode legal.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIWB = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [1:0] {
      SRCB_REGB    = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } srcb_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_t;

   typedef struct packed {
      logic   pc_write;
      logic   pc_write_cond;
      logic   iord;
      logic   mem_read;
      logic   mem_write;
      logic   ir_write;
      logic   mem_to_reg;
      logic   reg_write;
      logic   reg_dst;
      logic   alu_src_a;
      srcb_t  alu_src_b;
      aluop_t alu_op;
      pcsrc_t pc_source;
      logic   done;
      logic   illegal;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ);
`ifdef CONTROL_FSM_JUMP_EN
      ok = ok || (op == OP_J);
`endif
      return ok;
   endfunction

endpackage

// File: rtl/control_fsm_outdec.sv
// Combinational Moore decode: state + mem_ready -> datapath strobes.
// rst forces every strobe low regardless of state.
module control_fsm_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   bad_op,
   input  logic   rst,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.illegal   = bad_op;
            ctrl.done      = bad_op;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.done       = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.done      = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.done      = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.done      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.done          = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.done      = 1'b1;
         end
         default: ctrl = '0;
      endcase
      if (rst) ctrl = '0;
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control FSM: state register and next-state logic.
// Build with CONTROL_FSM_JUMP_EN to add the j instruction (JUMP state).
module control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int HANDSHAKE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       done,
   output logic       illegal
);

   state_t cur, nxt;
   ctrl_t  ctrl;
   logic   mr;
   logic   bad_op;

   // Without the handshake every memory access completes in one cycle.
   assign mr     = (HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign bad_op = !op_legal(opcode);

   always_comb begin
      nxt = cur;
      unique case (cur)
         S_FETCH:  if (mr) nxt = S_DECODE;
         S_DECODE: begin
            if (bad_op)                                  nxt = S_FETCH;
            else if (opcode == OP_RTYPE)                 nxt = S_EXEC;
            else if (opcode == OP_BEQ)                   nxt = S_BRANCH;
            else if (opcode == OP_J)                     nxt = S_JUMP;
            else                                         nxt = S_MEMADR;
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      nxt = S_MEMRD;
            else if (opcode == OP_SW) nxt = S_MEMWR;
            else                      nxt = S_ADDIWB;
         end
         S_MEMRD:  if (mr) nxt = S_MEMWB;
         S_MEMWR:  if (mr) nxt = S_FETCH;
         S_EXEC:   nxt = S_ALUWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   control_fsm_outdec u_outdec (
      .state     (cur),
      .mem_ready (mr),
      .bad_op    (bad_op),
      .rst       (rst),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUOp       = ctrl.alu_op;
   assign PCSource    = ctrl.pc_source;
   assign done        = ctrl.done;
   assign illegal     = ctrl.illegal;
   assign state       = rst ? 4'd0 : cur;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 opcode  input  6  instruction opcode from the instruction register; stable from DECODE until the instruction completes.
REQ-005 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  multi-cycle datapath strobes and selects.
REQ-007 ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 ALUOp  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-009 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 state  output  4  current state code, for debug and bench.
REQ-011 done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-013 Moore FSM: all outputs are decoded from the current state plus mem_ready; any output not listed for a state is 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready; stay until mem_ready, then go to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: 000000->EXEC, 100011/101011/001000->MEMADR, 000100->BRANCH, other->FETCH with illegal=1 and done=1.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEMRD, sw->MEMWR, addi->ADDIWB.
REQ-017 MEMRD: MemRead=1, IorD=1; wait for mem_ready, then go to MEMWB.
REQ-018 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, done=1; next state FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; wait for mem_ready; on mem_ready, done=1 and go to FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, done=1; next state FETCH.
REQ-022 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, done=1; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, done=1; next state FETCH.
REQ-024 MemRead and MemWrite are never both 1; RegWrite and any memory strobe are never both 1.
REQ-025 Latency with mem_ready held at 1: R-type 4, addi 4, lw 5, sw 4, beq 3, illegal 2 cycles; each cycle mem_ready is low in a wait state adds exactly one cycle.
REQ-026 If mem_ready is high outside FETCH, MEMRD or MEMWR, it is ignored.

Reset
REQ-027 While rst=1 at a rising edge, state becomes FETCH; while rst is high, every output is forced to 0 combinationally.
REQ-028 A reset in any state, including a memory wait, abandons the instruction with no done pulse; the first post-reset cycle is FETCH.

Configuration
REQ-029 Macro CONTROL_FSM_JUMP_EN: when defined, opcode 000010 goes from DECODE to JUMP (PCWrite=1, PCSource=10, done=1, then FETCH), so j takes 3 cycles; when undefined, 000010 is illegal and the JUMP state code is unreachable.

Structure
REQ-030 Shared package mips_ctrl_pkg holds the opcode constants, the 4-bit state codes (FETCH=0 ... JUMP=10), and the ALUOp, ALUSrcB and PCSource encodings.
REQ-031 One sub-module, control_fsm_outdec, provides the purely combinational state+mem_ready->outputs decode; the state register and next-state logic stay in control_fsm.

Verification
REQ-032 R-type (000000), mem_ready=1 -> states 0,1,EXEC,ALUWB; RegWrite=RegDst=1 and done=1 in cycle 4 only.
REQ-033 lw (100011), mem_ready low for 2 cycles in MEMRD -> 7 cycles total; MemtoReg=RegWrite=1 in the last cycle; MemWrite never asserts.
REQ-034 beq (000100) -> 3 cycles; PCWriteCond=1, ALUOp=01, PCSource=01 in cycle 3.
REQ-035 opcode 111111 -> illegal=1 and done=1 in DECODE, back to FETCH in cycle 3, RegWrite/MemWrite never assert.
REQ-036 sw waiting in MEMWR with mem_ready=0, rst pulsed -> all outputs 0 during rst, state=FETCH next cycle, no done pulse.
REQ-037 opcode 000010 -> with CONTROL_FSM_JUMP_EN defined: PCWrite=1, PCSource=10 in cycle 3; without it: illegal pulse.
